xbar_main_nm: RTL

- N-master to 1-slave TileLink-UL crossbar. Successor to the single-master pass-through xbar.
- Sits between N host ports and the CDC adapter, carrying both A and D channels.
- Channel A uses round-robin arbitration with grant lock while stalled. Each accepted request's source is tagged with the master index.
- Channel D responses are routed back to the originating master by the tag bits.
- A per-master outstanding-request limit is enforced.
- All messages are single-beat (UL Get/PutFull/PutPartial and their AccessAck variants).

---
 rtl/xbar_main_nm.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/xbar_main_nm.sv
// N-master to 1-slave TileLink-UL crossbar: round-robin A arbitration with grant lock on stall,
// master-index source tagging, D routing by tag and per-master outstanding-request limits.
module xbar_main_nm #(
  parameter int unsigned N_MASTERS       = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MASK_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH      = 3,
  parameter int unsigned OPCODE_WIDTH    = 3,
  parameter int unsigned PARAM_WIDTH     = 3,
  parameter int unsigned SRC_WIDTH       = 2,
  parameter int unsigned IDX_WIDTH       = $clog2(N_MASTERS),
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [N_MASTERS-1:0]              i_a_valid,
  output logic [N_MASTERS-1:0]              o_a_ready,
  input  logic [N_MASTERS*OPCODE_WIDTH-1:0] i_a_opcode,
  input  logic [N_MASTERS*PARAM_WIDTH-1:0]  i_a_param,
  input  logic [N_MASTERS*SIZE_WIDTH-1:0]   i_a_size,
  input  logic [N_MASTERS*SRC_WIDTH-1:0]    i_a_source,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]   i_a_address,
  input  logic [N_MASTERS*MASK_WIDTH-1:0]   i_a_mask,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]   i_a_data,
  output logic [N_MASTERS-1:0]              o_d_valid,
  input  logic [N_MASTERS-1:0]              i_d_ready,
  output logic [N_MASTERS*OPCODE_WIDTH-1:0] o_d_opcode,
  output logic [N_MASTERS*PARAM_WIDTH-1:0]  o_d_param,
  output logic [N_MASTERS*SIZE_WIDTH-1:0]   o_d_size,
  output logic [N_MASTERS*DATA_WIDTH-1:0]   o_d_data,
  output logic [N_MASTERS*SRC_WIDTH-1:0]    o_d_source,
  output logic [N_MASTERS-1:0]              o_d_sink,
  output logic [N_MASTERS-1:0]              o_d_error,
  output logic                              o_a_valid_out,
  input  logic                              i_a_ready_out,
  output logic [OPCODE_WIDTH-1:0]           o_a_opcode_out,
  output logic [PARAM_WIDTH-1:0]            o_a_param_out,
  output logic [SIZE_WIDTH-1:0]             o_a_size_out,
  output logic [ADDR_WIDTH-1:0]             o_a_address_out,
  output logic [MASK_WIDTH-1:0]             o_a_mask_out,
  output logic [DATA_WIDTH-1:0]             o_a_data_out,
  output logic [IDX_WIDTH+SRC_WIDTH-1:0]    o_a_source_out,
  input  logic                              i_d_valid_in,
  output logic                              o_d_ready_in,
  input  logic [OPCODE_WIDTH-1:0]           i_d_opcode_in,
  input  logic [PARAM_WIDTH-1:0]            i_d_param_in,
  input  logic [SIZE_WIDTH-1:0]             i_d_size_in,
  input  logic                              i_d_sink_in,
  input  logic [DATA_WIDTH-1:0]             i_d_data_in,
  input  logic                              i_d_error_in,
  input  logic [IDX_WIDTH+SRC_WIDTH-1:0]    i_d_source_in,
  output logic                              o_route_err
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [IDX_WIDTH-1:0] r_rr_ptr;
  logic [IDX_WIDTH-1:0] r_lock_idx;
  logic                 r_lock;
  logic [CNT_WIDTH-1:0] r_cnt [N_MASTERS];

  logic [N_MASTERS-1:0] w_eligible;
  logic [IDX_WIDTH-1:0] w_grant;
  logic [IDX_WIDTH-1:0] w_cand;
  logic                 w_found;
  logic [IDX_WIDTH-1:0] w_rr_next;
  logic                 w_a_fire;
  logic [IDX_WIDTH-1:0] w_d_idx;
  logic [SRC_WIDTH-1:0] w_d_src;
  logic [N_MASTERS-1:0] w_d_hit;
  logic                 w_d_sel_ready;
  logic                 w_d_fire;
  logic [N_MASTERS-1:0] w_cnt_inc;
  logic [N_MASTERS-1:0] w_cnt_dec;

  always_comb begin
    for (int unsigned m = 0; m < N_MASTERS; m++) begin
      w_eligible[m] = i_a_valid[m] && (32'(r_cnt[m]) < MAX_OUTSTANDING);
    end
  end

  // A locked grant holds its master until it fires, so newcomers cannot preempt a stall.
  always_comb begin
    w_grant = r_lock_idx;
    w_cand  = '0;
    w_found = 1'b0;
    if (!r_lock) begin
      w_grant = r_rr_ptr;
      for (int unsigned k = 0; k < N_MASTERS; k++) begin
        w_cand = IDX_WIDTH'((32'(r_rr_ptr) + k) % N_MASTERS);
        if (!w_found && w_eligible[w_cand]) begin
          w_grant = w_cand;
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_rr_next = IDX_WIDTH'((32'(w_grant) + 32'd1) % N_MASTERS);

  assign o_a_valid_out   = !i_reset && w_eligible[w_grant];
  assign w_a_fire        = o_a_valid_out && i_a_ready_out;
  assign o_a_opcode_out  = i_a_opcode[w_grant*OPCODE_WIDTH +: OPCODE_WIDTH];
  assign o_a_param_out   = i_a_param[w_grant*PARAM_WIDTH +: PARAM_WIDTH];
  assign o_a_size_out    = i_a_size[w_grant*SIZE_WIDTH +: SIZE_WIDTH];
  assign o_a_address_out = i_a_address[w_grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign o_a_mask_out    = i_a_mask[w_grant*MASK_WIDTH +: MASK_WIDTH];
  assign o_a_data_out    = i_a_data[w_grant*DATA_WIDTH +: DATA_WIDTH];
  assign o_a_source_out  = {w_grant, i_a_source[w_grant*SRC_WIDTH +: SRC_WIDTH]};

  always_comb begin
    o_a_ready = '0;
    if (!i_reset) o_a_ready[w_grant] = i_a_ready_out;
  end

  assign w_d_idx = i_d_source_in[SRC_WIDTH +: IDX_WIDTH];
  assign w_d_src = i_d_source_in[SRC_WIDTH-1:0];

  // An out-of-range tag matches no master and is sunk with ready held high.
  always_comb begin
    w_d_hit       = '0;
    w_d_sel_ready = 1'b1;
    for (int unsigned m = 0; m < N_MASTERS; m++) begin
      if (32'(w_d_idx) == m) begin
        w_d_hit[m]    = 1'b1;
        w_d_sel_ready = i_d_ready[m];
      end
    end
  end

  assign o_d_valid    = i_reset ? '0 : (w_d_hit & {N_MASTERS{i_d_valid_in}});
  assign o_d_ready_in = !i_reset && w_d_sel_ready;
  assign w_d_fire     = i_d_valid_in && o_d_ready_in;
  assign o_route_err  = !i_reset && i_d_valid_in && !(|w_d_hit);

  assign o_d_opcode = {N_MASTERS{i_d_opcode_in}};
  assign o_d_param  = {N_MASTERS{i_d_param_in}};
  assign o_d_size   = {N_MASTERS{i_d_size_in}};
  assign o_d_data   = {N_MASTERS{i_d_data_in}};
  assign o_d_source = {N_MASTERS{w_d_src}};
  assign o_d_sink   = {N_MASTERS{i_d_sink_in}};
  assign o_d_error  = {N_MASTERS{i_d_error_in}};

  always_comb begin
    for (int unsigned m = 0; m < N_MASTERS; m++) begin
      w_cnt_inc[m] = w_a_fire && (32'(w_grant) == m);
      w_cnt_dec[m] = w_d_fire && w_d_hit[m];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      for (int unsigned m = 0; m < N_MASTERS; m++) r_cnt[m] <= '0;
    end else begin
      if (w_a_fire) begin
        r_rr_ptr <= w_rr_next;
        r_lock   <= 1'b0;
      end else if (o_a_valid_out) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end
      for (int unsigned m = 0; m < N_MASTERS; m++) begin
        if (w_cnt_inc[m] && !w_cnt_dec[m]) begin
          r_cnt[m] <= r_cnt[m] + CntOne;
        end else if (w_cnt_dec[m] && !w_cnt_inc[m] && (r_cnt[m] != '0)) begin
          r_cnt[m] <= r_cnt[m] - CntOne;
        end
      end
    end
  end

endmodule
